// File: rtl/psr_icc_unit_if.sv
// Bus bundle for psr_icc_unit: ALU flags, WRPSR/WRWIM writes,
// window/trap events in; committed PSR/WIM and status pulses out.
interface psr_icc_unit_if #(
   parameter int NWINDOWS = 8
);
   // Requests toward the status unit
   logic                icc_we;
   logic                alu_n;
   logic                alu_z;
   logic                alu_c;
   logic                alu_v;
   logic                psr_wr;
   logic [31:0]         psr_wdata;
   logic                wim_wr;
   logic [NWINDOWS-1:0] wim_wdata;
   logic                cwp_dec;
   logic                cwp_inc;
   logic                trap_enter;
   logic                rett;
   logic [3:0]          cond;

   // Status returned by the unit
   logic [31:0]         psr;
   logic [NWINDOWS-1:0] wim;
   logic                ci;
   logic                cond_true;
   logic                win_overflow;
   logic                win_underflow;
   logic                illegal_wr;
   logic                rett_err;
   logic                error_mode;
   logic                wr_pending;

   // Pipeline side that issues requests
   modport master (
      output icc_we, alu_n, alu_z, alu_c, alu_v,
      output psr_wr, psr_wdata, wim_wr, wim_wdata,
      output cwp_dec, cwp_inc, trap_enter, rett, cond,
      input  psr, wim, ci, cond_true, win_overflow, win_underflow,
      input  illegal_wr, rett_err, error_mode, wr_pending
   );

   // Status unit side
   modport slave (
      input  icc_we, alu_n, alu_z, alu_c, alu_v,
      input  psr_wr, psr_wdata, wim_wr, wim_wdata,
      input  cwp_dec, cwp_inc, trap_enter, rett, cond,
      output psr, wim, ci, cond_true, win_overflow, win_underflow,
      output illegal_wr, rett_err, error_mode, wr_pending
   );
endinterface

// File: rtl/psr_icc_unit.sv
// Processor status unit: holds icc/EF/PIL/S/PS/ET/CWP and WIM, performs
// the delayed WRPSR commit, window moves, trap entry/return, and the
// Bicc condition evaluation on the registered icc.
module psr_icc_unit #(
   parameter int         NWINDOWS = 8,
   parameter int         WR_DELAY = 3,
   parameter logic [7:0] IMPL_VER = 8'h00
) (
   input logic           clk,
   input logic           reset,
   psr_icc_unit_if.slave bus
);

   localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);
   localparam logic [5:0] NW6     = 6'(NWINDOWS);
   localparam logic [2:0] DLY     = 3'(WR_DELAY);

   // Architectural PSR fields; icc is ordered {N,Z,V,C}
   logic [3:0]          icc_q, icc_d;
   logic                ef_q, ef_d;
   logic [3:0]          pil_q, pil_d;
   logic                s_q, s_d;
   logic                ps_q, ps_d;
   logic                et_q, et_d;
   logic [4:0]          cwp_q, cwp_d;
   logic [NWINDOWS-1:0] wim_q, wim_d;

   // In-flight WRPSR: {icc, EF, PIL, S, PS, ET, CWP}
   logic                pend_q, pend_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [16:0]         pdata_q, pdata_d;

   // Status pulses and sticky error
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;
   logic                ill_q, ill_d;
   logic                rerr_q, rerr_d;
   logic                err_q, err_d;

   // Window arithmetic helpers
   logic [4:0]          cwp_plus, cwp_minus;
   logic [NWINDOWS-1:0] wim_sh_plus, wim_sh_minus;
   logic                wim_at_plus, wim_at_minus;
   logic                wr_legal, wr_load, commit;
   logic                wdata_unused;

   // Fields the PSR does not implement are ignored on WRPSR
   assign wdata_unused = ^{bus.psr_wdata[31:24], bus.psr_wdata[19:13]};

   // Neighbouring window numbers, modulo NWINDOWS, and their WIM bits
   always_comb begin
      cwp_plus     = (cwp_q == CWP_MAX) ? 5'd0 : cwp_q + 5'd1;
      cwp_minus    = (cwp_q == 5'd0) ? CWP_MAX : cwp_q - 5'd1;
      wim_sh_plus  = wim_q >> cwp_plus;
      wim_sh_minus = wim_q >> cwp_minus;
      wim_at_plus  = wim_sh_plus[0];
      wim_at_minus = wim_sh_minus[0];
   end

   // Next-state logic: icc load, prioritised window/trap events, WRPSR queue and commit
   always_comb begin
      icc_d   = icc_q;
      ef_d    = ef_q;
      pil_d   = pil_q;
      s_d     = s_q;
      ps_d    = ps_q;
      et_d    = et_q;
      cwp_d   = cwp_q;
      wim_d   = wim_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      pdata_d = pdata_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      ill_d   = 1'b0;
      rerr_d  = 1'b0;
      err_d   = err_q;

      wr_legal = ({1'b0, bus.psr_wdata[4:0]} < NW6);
      wr_load  = bus.psr_wr && wr_legal;
      // A fresh legal WRPSR on the would-be commit edge supersedes the old one
      commit   = pend_q && (cnt_q == 3'd1) && !wr_load;

      if (bus.icc_we) begin
         icc_d = {bus.alu_n, bus.alu_z, bus.alu_v, bus.alu_c};
      end

      if (bus.trap_enter) begin
         if (et_q) begin
            ps_d  = s_q;
            s_d   = 1'b1;
            et_d  = 1'b0;
            cwp_d = cwp_minus;
         end else begin
            err_d = 1'b1;
         end
      end else if (bus.rett) begin
         if (!et_q) begin
            if (wim_at_plus) begin
               unf_d = 1'b1;
            end else begin
               cwp_d = cwp_plus;
               s_d   = ps_q;
               et_d  = 1'b1;
            end
         end else begin
            rerr_d = 1'b1;
         end
      end else if (bus.cwp_dec) begin
         if (wim_at_minus) begin
            ovf_d = 1'b1;
         end else begin
            cwp_d = cwp_minus;
         end
      end else if (bus.cwp_inc) begin
         if (wim_at_plus) begin
            unf_d = 1'b1;
         end else begin
            cwp_d = cwp_plus;
         end
      end

      if (bus.wim_wr) begin
         wim_d = bus.wim_wdata;
      end

      if (bus.psr_wr && !wr_legal) begin
         ill_d = 1'b1;
      end

      if (wr_load) begin
         pdata_d = {bus.psr_wdata[23:20], bus.psr_wdata[12], bus.psr_wdata[11:8],
                    bus.psr_wdata[7], bus.psr_wdata[6], bus.psr_wdata[5],
                    bus.psr_wdata[4:0]};
         cnt_d   = DLY;
         pend_d  = 1'b1;
      end else if (pend_q) begin
         cnt_d = cnt_q - 3'd1;
         if (cnt_q == 3'd1) begin
            pend_d = 1'b0;
         end
      end

      // The committing WRPSR owns every writable field this edge
      if (commit) begin
         icc_d = pdata_q[16:13];
         ef_d  = pdata_q[12];
         pil_d = pdata_q[11:8];
         s_d   = pdata_q[7];
         ps_d  = pdata_q[6];
         et_d  = pdata_q[5];
         cwp_d = pdata_q[4:0];
      end
   end

   // State registers with asynchronous reset to the architectural reset values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         icc_q   <= 4'd0;
         ef_q    <= 1'b0;
         pil_q   <= 4'd0;
         s_q     <= 1'b1;
         ps_q    <= 1'b0;
         et_q    <= 1'b0;
         cwp_q   <= 5'd0;
         wim_q   <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= 3'd0;
         pdata_q <= 17'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         ill_q   <= 1'b0;
         rerr_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         icc_q   <= icc_d;
         ef_q    <= ef_d;
         pil_q   <= pil_d;
         s_q     <= s_d;
         ps_q    <= ps_d;
         et_q    <= et_d;
         cwp_q   <= cwp_d;
         wim_q   <= wim_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         pdata_q <= pdata_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         ill_q   <= ill_d;
         rerr_q  <= rerr_d;
         err_q   <= err_d;
      end
   end

   // Bicc evaluation on registered icc; cond[3] inverts the base test
   always_comb begin
      logic base;
      logic n, z, v, c;
      {n, z, v, c} = icc_q;
      base = 1'b0;
      case (bus.cond[2:0])
         3'd0:    base = 1'b0;
         3'd1:    base = z;
         3'd2:    base = z | (n ^ v);
         3'd3:    base = n ^ v;
         3'd4:    base = c | z;
         3'd5:    base = c;
         3'd6:    base = n;
         default: base = v;
      endcase
      bus.cond_true = base ^ bus.cond[3];
   end

   assign bus.psr           = {IMPL_VER, icc_q, 7'd0, ef_q, pil_q, s_q, ps_q, et_q, cwp_q};
   assign bus.wim           = wim_q;
   assign bus.ci            = icc_q[0];
   assign bus.win_overflow  = ovf_q;
   assign bus.win_underflow = unf_q;
   assign bus.illegal_wr    = ill_q;
   assign bus.rett_err      = rerr_q;
   assign bus.error_mode    = err_q;
   assign bus.wr_pending    = pend_q;

endmodule

// File: tb/tb_psr_icc_unit.sv
// Directed bench for psr_icc_unit (NWINDOWS=8, WR_DELAY=3).
module tb_psr_icc_unit;

   localparam int NW = 8;

   logic clk;
   logic reset;
   int   n_assert = 0;
   int   n_fail   = 0;

   psr_icc_unit_if #(.NWINDOWS(NW)) bus ();

   psr_icc_unit #(.NWINDOWS(NW), .WR_DELAY(3), .IMPL_VER(8'h00)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
         $display("check %-16s observed %h expected %h", tag, obs, exp);
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp)
         $display("check %-16s observed %b expected %b", tag, obs, exp);
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.icc_we     = 1'b0;
      bus.alu_n      = 1'b0;
      bus.alu_z      = 1'b0;
      bus.alu_c      = 1'b0;
      bus.alu_v      = 1'b0;
      bus.psr_wr     = 1'b0;
      bus.psr_wdata  = 32'd0;
      bus.wim_wr     = 1'b0;
      bus.wim_wdata  = '0;
      bus.cwp_dec    = 1'b0;
      bus.cwp_inc    = 1'b0;
      bus.trap_enter = 1'b0;
      bus.rett       = 1'b0;
      bus.cond       = 4'd0;
   endtask

   // One clock edge, then settle; inputs are cleared after the edge
   task automatic step();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   // Issue WRPSR and wait for its commit (issue edge + 3 edges)
   task automatic write_psr(input logic [31:0] val);
      bus.psr_wr    = 1'b1;
      bus.psr_wdata = val;
      step();
      step();
      step();
      step();
   endtask

   logic [3:0] cond_vec [10];
   logic       cond_exp [10];

   initial begin
      reset = 1'b0;
      clear_inputs();
      #2 reset = 1'b1;
      #1;
      // Asynchronous reset takes effect before any clock edge
      check32("rst_psr_async", bus.psr, 32'h0000_0080);
      check32("rst_wim", 32'(bus.wim), 32'd0);
      check1("rst_pending", bus.wr_pending, 1'b0);
      check1("rst_error", bus.error_mode, 1'b0);
      check1("rst_illegal", bus.illegal_wr, 1'b0);
      check1("rst_ci", bus.ci, 1'b0);
      step();
      step();
      reset = 1'b0;
      step();
      check32("post_rst_psr", bus.psr, 32'h0000_0080);

      // icc load: n=0 z=1 c=1 v=0
      bus.icc_we = 1'b1;
      bus.alu_z  = 1'b1;
      bus.alu_c  = 1'b1;
      step();
      check32("icc_psr", bus.psr, 32'h0050_0080);
      check1("icc_ci", bus.ci, 1'b1);

      // icc = N0 Z1 V0 C1
      cond_vec = '{4'h1, 4'h4, 4'hC, 4'h0, 4'h8, 4'h2, 4'h3, 4'hB, 4'h7, 4'hD};
      cond_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         bus.cond = cond_vec[i];
         #1;
         check1($sformatf("cond_%h", cond_vec[i]), bus.cond_true, cond_exp[i]);
      end
      bus.cond = 4'd0;

      // Delayed WRPSR of 0xA3: unchanged for two more cycles, then committed
      bus.psr_wr    = 1'b1;
      bus.psr_wdata = 32'h0000_00A3;
      step();
      check1("wr_pend_t0", bus.wr_pending, 1'b1);
      check32("wr_psr_t0", bus.psr, 32'h0050_0080);
      step();
      check1("wr_pend_t1", bus.wr_pending, 1'b1);
      check32("wr_psr_t1", bus.psr, 32'h0050_0080);
      step();
      check1("wr_pend_t2", bus.wr_pending, 1'b1);
      check32("wr_psr_t2", bus.psr, 32'h0050_0080);
      step();
      check32("wr_psr_commit", bus.psr, 32'h0000_00A3);
      check1("wr_pend_done", bus.wr_pending, 1'b0);
      check1("wr_ci", bus.ci, 1'b0);

      // Illegal CWP=9 is rejected
      bus.psr_wr    = 1'b1;
      bus.psr_wdata = 32'h0000_0009;
      step();
      check1("ill_pulse", bus.illegal_wr, 1'b1);
      check1("ill_pending", bus.wr_pending, 1'b0);
      check32("ill_psr", bus.psr, 32'h0000_00A3);
      step();
      check1("ill_pulse_end", bus.illegal_wr, 1'b0);
      check32("ill_psr_later", bus.psr, 32'h0000_00A3);

      // Window management: S=1 ET=1 CWP=0
      write_psr(32'h0000_00A0);
      check32("win_setup", bus.psr, 32'h0000_00A0);
      bus.wim_wr    = 1'b1;
      bus.wim_wdata = 8'h80;
      step();
      check32("wim_set", 32'(bus.wim), 32'h80);
      bus.cwp_dec = 1'b1;
      step();
      check1("ovf_pulse", bus.win_overflow, 1'b1);
      check32("ovf_psr", bus.psr, 32'h0000_00A0);
      step();
      check1("ovf_pulse_end", bus.win_overflow, 1'b0);
      // Same-cycle WIM write: check still uses the old mask
      bus.wim_wr    = 1'b1;
      bus.wim_wdata = 8'h00;
      bus.cwp_dec   = 1'b1;
      step();
      check1("ovf_old_wim", bus.win_overflow, 1'b1);
      check32("wim_cleared", 32'(bus.wim), 32'd0);
      check32("ovf_old_psr", bus.psr, 32'h0000_00A0);
      bus.cwp_dec = 1'b1;
      step();
      check32("dec_wrap", bus.psr, 32'h0000_00A7);
      check1("dec_no_ovf", bus.win_overflow, 1'b0);
      bus.wim_wr    = 1'b1;
      bus.wim_wdata = 8'h01;
      step();
      bus.cwp_inc = 1'b1;
      step();
      check1("unf_pulse", bus.win_underflow, 1'b1);
      check32("unf_psr", bus.psr, 32'h0000_00A7);
      bus.wim_wr    = 1'b1;
      bus.wim_wdata = 8'h00;
      step();
      check1("unf_pulse_end", bus.win_underflow, 1'b0);
      // dec outranks inc
      bus.cwp_dec = 1'b1;
      bus.cwp_inc = 1'b1;
      step();
      check32("prio_dec", bus.psr, 32'h0000_00A6);
      bus.cwp_inc = 1'b1;
      step();
      check32("inc_7", bus.psr, 32'h0000_00A7);
      bus.cwp_inc = 1'b1;
      step();
      check32("inc_wrap", bus.psr, 32'h0000_00A0);

      // Traps: S=0 PS=0 ET=1 CWP=4
      write_psr(32'h0000_0024);
      check32("trap_setup", bus.psr, 32'h0000_0024);
      bus.trap_enter = 1'b1;
      step();
      check32("trap_psr", bus.psr, 32'h0000_0083);
      check1("trap_no_err", bus.error_mode, 1'b0);
      bus.trap_enter = 1'b1;
      step();
      check1("trap_err", bus.error_mode, 1'b1);
      check32("trap_err_psr", bus.psr, 32'h0000_0083);
      bus.rett = 1'b1;
      step();
      check32("rett_psr", bus.psr, 32'h0000_0024);
      check1("err_sticky", bus.error_mode, 1'b1);
      bus.rett = 1'b1;
      step();
      check1("rett_err", bus.rett_err, 1'b1);
      check32("rett_err_psr", bus.psr, 32'h0000_0024);
      step();
      check1("rett_err_end", bus.rett_err, 1'b0);

      // icc load alongside a window move: N1 Z0 V1 C0, CWP 4->3
      bus.icc_we  = 1'b1;
      bus.alu_n   = 1'b1;
      bus.alu_v   = 1'b1;
      bus.cwp_dec = 1'b1;
      step();
      check32("icc_and_dec", bus.psr, 32'h00A0_0023);
      bus.cond = 4'h3;
      #1;
      check1("cond_3_nv", bus.cond_true, 1'b0);
      bus.cond = 4'h6;
      #1;
      check1("cond_6_n", bus.cond_true, 1'b1);
      bus.cond = 4'hE;
      #1;
      check1("cond_e_nn", bus.cond_true, 1'b0);
      bus.cond = 4'h0;

      // Commit-edge collision: WRPSR wins over icc_we and cwp_inc
      bus.psr_wr    = 1'b1;
      bus.psr_wdata = 32'h00F0_00A5;
      step();
      step();
      step();
      check1("coll_pending", bus.wr_pending, 1'b1);
      check32("coll_before", bus.psr, 32'h00A0_0023);
      bus.icc_we  = 1'b1;
      bus.cwp_inc = 1'b1;
      step();
      check32("coll_commit", bus.psr, 32'h00F0_00A5);
      check1("coll_pend_done", bus.wr_pending, 1'b0);

      // Reset two cycles into a pending write drops it
      bus.psr_wr    = 1'b1;
      bus.psr_wdata = 32'h0000_0041;
      step();
      step();
      step();
      reset = 1'b1;
      #1;
      check32("midrst_psr", bus.psr, 32'h0000_0080);
      check1("midrst_pending", bus.wr_pending, 1'b0);
      check1("midrst_error", bus.error_mode, 1'b0);
      step();
      reset = 1'b0;
      step();
      step();
      step();
      step();
      check32("midrst_psr_late", bus.psr, 32'h0000_0080);
      check1("midrst_pend_late", bus.wr_pending, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/psr_icc_unit.md
Name: psr_icc_unit

Overview:
- Processor-status stage directly downstream of the execute-stage ALU in the SPARC-V8-style datapath.
- Captures the ALU's N/Z/C/V outputs into the PSR icc field when a cc-modifying op executes.
- Feeds the carry back to the ALU's Ci input and evaluates Bicc branch conditions.
- Owns CWP/WIM window management and the delayed WRPSR write, and flags window overflow/underflow and trap-sequencing errors.

Parameters:
- NWINDOWS, 8: number of register windows; CWP arithmetic is modulo NWINDOWS; legal range 2..32.
- WR_DELAY, 3: cycles from psr_wr to the WRPSR commit; legal range 1..7.
- IMPL_VER, 8'h00: constant value of PSR[31:24].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- icc_we  in  1  load icc from alu_n/z/v/c this cycle.
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs.
- psr_wr  in  1  WRPSR issue.
- psr_wdata  in  32  WRPSR value.
- wim_wr  in  1  WRWIM, immediate effect.
- wim_wdata  in  NWINDOWS  new WIM.
- cwp_dec  in  1  SAVE.
- cwp_inc  in  1  RESTORE.
- trap_enter  in  1  trap entry.
- rett  in  1  return from trap.
- cond  in  4  Bicc condition field.
- psr  out  32  committed PSR.
- wim  out  NWINDOWS  committed WIM.
- ci  out  1  psr[20] (C), wired to the ALU Ci input.
- cond_true  out  1  combinational result of cond applied to the registered icc.
- win_overflow, win_underflow  out  1  one-cycle pulses.
- illegal_wr  out  1  one-cycle pulse on a rejected WRPSR.
- rett_err  out  1  one-cycle pulse on a rejected RETT.
- error_mode  out  1  sticky flag; cleared only by reset.
- wr_pending  out  1  high while a WRPSR is in flight.

Behaviour:
- PSR layout: [31:24] IMPL_VER; [23] N; [22] Z; [21] V; [20] C; [19:13] 0; [12] EF; [11:8] PIL; [7] S; [6] PS; [5] ET; [4:0] CWP.
- Reset values (asynchronous):
  - icc = 0, EF = 0, PIL = 0, S = 1, PS = 0, ET = 0, CWP = 0.
  - wim = 0, pending = 0, delay counter = 0.
  - All pulse outputs 0; error_mode = 0.
- icc_we: on the next edge, {N,Z,V,C} <= {alu_n, alu_z, alu_v, alu_c}. There is no forwarding; cond_true reflects the registered icc only.
- WRPSR issue (psr_wr):
  - If psr_wdata[4:0] >= NWINDOWS: pulse illegal_wr the next cycle and queue nothing.
  - Otherwise latch the writable fields (icc, EF, PIL, S, PS, ET, CWP), load the counter with WR_DELAY and set wr_pending.
  - A new psr_wr while one is pending replaces the latched data and restarts the count.
- Counter decrements each cycle while pending. The commit happens on the edge where the counter goes 1->0; wr_pending drops on that same edge.
- At the commit edge, WRPSR data overrides every other same-cycle PSR update: icc_we, cwp_inc/cwp_dec, trap_enter and rett are discarded for the fields WRPSR writes.
- Reset mid-count drops the pending write.
- Window and trap events are mutually prioritised: trap_enter > rett > cwp_dec > cwp_inc. Only the highest-priority asserted event acts.
- trap_enter:
  - ET = 1: PS <= S, S <= 1, ET <= 0, CWP <= (CWP-1) mod NWINDOWS, with no WIM check.
  - ET = 0: set error_mode; no PSR change.
- rett:
  - ET = 0: new = (CWP+1) mod NWINDOWS. If wim[new] = 1, pulse win_underflow with no change. Otherwise CWP <= new, S <= PS, ET <= 1.
  - ET = 1: pulse rett_err, no change.
- cwp_dec: new = (CWP-1) mod NWINDOWS. If wim[new] = 1, pulse win_overflow and leave CWP unchanged; otherwise CWP <= new.
- cwp_inc: new = (CWP+1) mod NWINDOWS. If wim[new] = 1, pulse win_underflow and leave CWP unchanged; otherwise CWP <= new.
- Wrap-around: CWP = 0 decrements to NWINDOWS-1; CWP = NWINDOWS-1 increments to 0.
- icc_we combines with any window or trap event in the same cycle, since they touch disjoint fields.
- wim_wr takes effect on the next edge. A WIM check in that same cycle uses the old wim.
- cond encoding for cond_true:
  - 0 never; 1 Z; 2 Z|(N^V); 3 N^V.
  - 4 C|Z; 5 C; 6 N; 7 V.
  - 8 always; 9 ~Z; A ~(Z|(N^V)); B ~(N^V).
  - C ~(C|Z); D ~C; E ~N; F ~V.

Test Plan:
- Reset, then icc_we with n=0, z=1, c=1, v=0 -> psr[23:20] = 4'b0101, ci = 1; cond=1 -> 1, cond=4 -> 1, cond=C -> 0.
- psr_wr with 32'h000000A3 at cycle t (NWINDOWS=8, WR_DELAY=3) -> psr unchanged at t+1 and t+2; psr[7:0] = 8'hA3 at t+3; wr_pending high from t+1 through t+2.
- psr_wr with CWP = 5'd9 -> illegal_wr pulse, wr_pending stays 0, psr unchanged.
- wim = 8'h80, CWP = 0, cwp_dec -> win_overflow pulse, CWP stays 0. With wim = 0: cwp_dec from 0 -> CWP = 7; cwp_inc from 7 -> CWP = 0.
- With ET=1, S=0: trap_enter -> S=1, PS=0, ET=0, CWP-1. A second trap_enter -> error_mode = 1. rett -> S=0, ET=1, CWP restored. rett again -> rett_err pulse.
- Commit-edge collision: icc_we and cwp_inc asserted on the commit cycle -> only the WRPSR values appear. Reset asserted two cycles after psr_wr -> pending dropped, reset PSR retained.
